// File: rtl/operand_loader_if.sv
// Downstream operand-pair channel: the two operands plus the valid/ready handshake.
interface operand_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             valid;
  logic             ready;

  modport master (output a, output b, output valid, input ready);
  modport slave  (input a, input b, input valid, output ready);
endinterface

// File: rtl/operand_loader.sv
// Operand loader: captures A then B from the pin bus on synchronized load
// strobes and offers the pair downstream with a registered valid/ready handshake.
module operand_loader #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [WIDTH-1:0]    din,
  input  logic                load,
  input  logic                clr,
  operand_loader_if.master    bus,
  output logic                overrun,
  output logic [1:0]          state,
  output logic [7:0]          pair_cnt
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   edge_r;
  logic                   load_evt_s;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             valid_r, valid_s;
  logic             overrun_r, overrun_s;
  logic [7:0]       cnt_r, cnt_s;

  // Strobe synchronizer and edge-detect history; keeps running while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], load};
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign load_evt_s = sync_r[SYNC_STAGES-1] & ~edge_r;

  // Next-state and next-output logic; clr outranks ena and every FSM action.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    valid_s   = valid_r;
    overrun_s = overrun_r;
    cnt_s     = cnt_r;
    if (clr) begin
      state_s   = WAIT_A;
      valid_s   = 1'b0;
      overrun_s = 1'b0;
    end else if (ena) begin
      case (state_r)
        WAIT_A: begin
          if (load_evt_s) begin
            a_s     = din;
            state_s = WAIT_B;
          end else begin
            state_s = WAIT_A;
          end
        end
        WAIT_B: begin
          if (load_evt_s) begin
            b_s     = din;
            valid_s = 1'b1;
            state_s = ISSUE;
          end else begin
            state_s = WAIT_B;
          end
        end
        ISSUE: begin
          // A strobe here is dropped but remembered, even if the handshake completes.
          if (load_evt_s) begin
            overrun_s = 1'b1;
          end else begin
            overrun_s = overrun_r;
          end
          if (valid_r && bus.ready) begin
            cnt_s   = cnt_r + 8'd1;
            valid_s = 1'b0;
            state_s = WAIT_A;
          end else begin
            valid_s = 1'b1;
            state_s = ISSUE;
          end
        end
        default: begin
          state_s = WAIT_A;
          valid_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= WAIT_A;
      a_r       <= '0;
      b_r       <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
      cnt_r     <= 8'd0;
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      valid_r   <= valid_s;
      overrun_r <= overrun_s;
      cnt_r     <= cnt_s;
    end
  end

  assign bus.a     = a_r;
  assign bus.b     = b_r;
  assign bus.valid = valid_r;
  assign overrun   = overrun_r;
  assign state     = state_r;
  assign pair_cnt  = cnt_r;

endmodule

// File: tb/tb_operand_loader.sv
// Directed self-checking bench for operand_loader.
module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] din;
  logic       load;
  logic       clr;
  logic       overrun;
  logic [1:0] state;
  logic [7:0] pair_cnt;

  int checks;
  int errors;

  operand_loader_if #(.WIDTH(8)) bus ();

  operand_loader #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .din      (din),
    .load     (load),
    .clr      (clr),
    .bus      (bus),
    .overrun  (overrun),
    .state    (state),
    .pair_cnt (pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    din = 8'h00;
    load = 1'b0;
    clr = 1'b0;
    bus.ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  // Load strobe high for 4 cycles, then low for 4; din held throughout.
  task automatic do_load(input logic [7:0] val);
    din = val;
    load = 1'b1;
    repeat (4) step();
    load = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.a, bus.b, bus.valid, overrun, state, pair_cnt} !== 29'd0) begin
      errors++;
      $display("FAIL reset: a=%h b=%h valid=%b ovr=%b state=%0d cnt=%0d expected all zero",
               bus.a, bus.b, bus.valid, overrun, state, pair_cnt);
    end
  endtask

  task automatic test_basic();
    int vcount;
    do_reset();
    bus.ready = 1'b1;
    do_load(8'hF0);
    checks++;
    if (bus.a !== 8'hF0 || state !== 2'd1) begin
      errors++;
      $display("FAIL basic_a: a=%h state=%0d expected a=f0 state=1", bus.a, state);
    end
    vcount = 0;
    din = 8'h3C;
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) load = 1'b0;
      step();
      if (bus.valid === 1'b1) vcount++;
    end
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL basic_valid_len: valid cycles=%0d expected 1", vcount);
    end
    checks++;
    if (bus.b !== 8'h3C || pair_cnt !== 8'd1 || state !== 2'd0) begin
      errors++;
      $display("FAIL basic_pair: b=%h cnt=%0d state=%0d expected b=3c cnt=1 state=0",
               bus.b, pair_cnt, state);
    end
  endtask

  task automatic test_hold();
    int bad;
    do_reset();
    do_load(8'hF0);
    do_load(8'h3C);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.valid !== 1'b1 || bus.a !== 8'hF0 || bus.b !== 8'h3C) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hold_stable: unstable cycles=%0d expected 0", bad);
    end
    bus.ready = 1'b1;
    step();
    checks++;
    if (bus.valid !== 1'b0 || pair_cnt !== 8'd1 || state !== 2'd0) begin
      errors++;
      $display("FAIL hold_accept: valid=%b cnt=%0d state=%0d expected valid=0 cnt=1 state=0",
               bus.valid, pair_cnt, state);
    end
    bus.ready = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    do_load(8'hF0);
    do_load(8'h3C);
    do_load(8'hAA);
    checks++;
    if (overrun !== 1'b1 || bus.b !== 8'h3C || state !== 2'd2) begin
      errors++;
      $display("FAIL overrun_set: ovr=%b b=%h state=%0d expected ovr=1 b=3c state=2",
               overrun, bus.b, state);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || state !== 2'd0 || bus.valid !== 1'b0 ||
        bus.a !== 8'hF0 || bus.b !== 8'h3C) begin
      errors++;
      $display("FAIL overrun_clr: ovr=%b state=%0d valid=%b a=%h b=%h expected 0 0 0 f0 3c",
               overrun, state, bus.valid, bus.a, bus.b);
    end
  endtask

  task automatic test_sync();
    do_reset();
    din = 8'h5A;
    load = 1'b1;
    repeat (2) step();
    checks++;
    if (bus.a !== 8'h00) begin
      errors++;
      $display("FAIL sync_early: a=%h expected 00 after 2 edges", bus.a);
    end
    step();
    checks++;
    if (bus.a !== 8'h5A || state !== 2'd1) begin
      errors++;
      $display("FAIL sync_latency: a=%h state=%0d expected a=5a state=1", bus.a, state);
    end
    repeat (17) step();
    checks++;
    if (state !== 2'd1 || bus.b !== 8'h00) begin
      errors++;
      $display("FAIL sync_held: state=%0d b=%h expected state=1 b=00", state, bus.b);
    end
    load = 1'b0;
    repeat (4) step();
    din = 8'h77;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (6) step();
    checks++;
    if (state !== 2'd2 || bus.b !== 8'h77 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL sync_glitch: state=%0d b=%h ovr=%b expected state=2 b=77 ovr=0",
               state, bus.b, overrun);
    end
  endtask

  task automatic test_ena();
    do_reset();
    bus.ready = 1'b1;
    do_load(8'hF0);
    ena = 1'b0;
    do_load(8'h55);
    checks++;
    if (state !== 2'd1 || bus.a !== 8'hF0 || bus.b !== 8'h00 || pair_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ena_gate: state=%0d a=%h b=%h cnt=%0d expected 1 f0 00 0",
               state, bus.a, bus.b, pair_cnt);
    end
    ena = 1'b1;
    do_load(8'h3C);
    checks++;
    if (bus.b !== 8'h3C || pair_cnt !== 8'd1 || state !== 2'd0) begin
      errors++;
      $display("FAIL ena_resume: b=%h cnt=%0d state=%0d expected 3c 1 0",
               bus.b, pair_cnt, state);
    end
    bus.ready = 1'b0;
    do_load(8'h11);
    do_load(8'h22);
    ena = 1'b0;
    bus.ready = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.valid !== 1'b1 || pair_cnt !== 8'd1 || state !== 2'd2) begin
      errors++;
      $display("FAIL ena_hs_hold: valid=%b cnt=%0d state=%0d expected 1 1 2",
               bus.valid, pair_cnt, state);
    end
    ena = 1'b1;
    step();
    checks++;
    if (bus.valid !== 1'b0 || pair_cnt !== 8'd2 || state !== 2'd0) begin
      errors++;
      $display("FAIL ena_hs_done: valid=%b cnt=%0d state=%0d expected 0 2 0",
               bus.valid, pair_cnt, state);
    end
    bus.ready = 1'b0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    bus.ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      do_load(8'h01);
      do_load(8'h02);
    end
    checks++;
    if (pair_cnt !== 8'd255) begin
      errors++;
      $display("FAIL wrap_255: cnt=%0d expected 255", pair_cnt);
    end
    do_load(8'h01);
    do_load(8'h02);
    checks++;
    if (pair_cnt !== 8'd0) begin
      errors++;
      $display("FAIL wrap_0: cnt=%0d expected 0", pair_cnt);
    end
    do_load(8'h03);
    do_load(8'h04);
    do_load(8'h99);
    checks++;
    if (state !== 2'd1 || bus.a !== 8'h99 || pair_cnt !== 8'd1) begin
      errors++;
      $display("FAIL pre_reset: state=%0d a=%h cnt=%0d expected 1 99 1", state, bus.a, pair_cnt);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.a, bus.b, bus.valid, overrun, state, pair_cnt} !== 29'd0) begin
      errors++;
      $display("FAIL async_reset: a=%h b=%h valid=%b ovr=%b state=%0d cnt=%0d expected all zero",
               bus.a, bus.b, bus.valid, overrun, state, pair_cnt);
    end
    #10;
    rst_n = 1'b1;
    bus.ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_hold();
    test_overrun();
    test_sync();
    test_ena();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
